sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO. It is the successor to the team's fixed 8-bit/16-entry FIFO, with configurable data width and depth, true full at DEPTH entries, concurrent read and write in one cycle, an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It sits between producer and consumer logic in a single clock domain and is the standard buffering primitive for new datapath blocks.

## Interface
- DATA_W, default 8: data width in bits, ≥1.
- DEPTH, default 16: number of entries; must be a power of 2 and ≥2.
- AF_LEVEL, default DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, default 2: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- CW (derived, not overridable) = $clog2(DEPTH)+1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- we  in  1  write request.
- wdata  in  DATA_W  write data, sampled on an accepted write.
- re  in  1  read request.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  high for one cycle when rdata holds newly read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was rejected.
- underflow  out  1  sticky; a read was rejected.

## Operation
- Storage is a DEPTH×DATA_W array. wptr and rptr are each log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. count is a separate CW-bit register.
- wr_ok = we && (!full || rd_ok).
- rd_ok = re && !empty.
- Because of these definitions, a write while full is accepted only when a read is accepted in the same cycle. A read while empty is always rejected; there is no fall-through.
- Accepted write: mem[wptr] ← wdata, and wptr increments.
- Accepted read: rdata ← mem[rptr], rptr increments, and rvalid = 1 in the next cycle. Otherwise rvalid = 0 and rdata holds its value.
- count update:
  - wr_ok && !rd_ok: count + 1.
  - rd_ok && !wr_ok: count − 1.
  - Both or neither: count is unchanged.
- Invariant: count equals (wptr − rptr) mod DEPTH, with full distinguishing the count == DEPTH case.
- Error flags:
  - overflow sets when we && !wr_ok.
  - underflow sets when re && !rd_ok.
  - Both stay set until rst; they are never cleared by other traffic.
- Rejected operations do not change mem, the pointers, or count.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the count register. They are glitch-free relative to clk and carry no combinational path from we or re.

## Timing
- Reset (rst high at a rising edge) forces: wptr = 0, rptr = 0, count = 0, rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
- Resulting flag values after reset: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0), which is 0 with legal parameters.
- Reset takes priority over we and re in the same cycle. Reset mid-stream discards all contents. Stale mem contents are not cleared and are unobservable.
- Write-to-read latency: data written at edge N can be read at edge N+1 (re sampled high at N+1). It appears on rdata with rvalid after edge N+1.
- Read latency: one cycle from an accepted re to rdata/rvalid.
- Flags and count reflect the state after each edge, with no extra pipeline delay.
- Full throughput: one write and one read per cycle sustained at any occupancy from 1 to DEPTH.

## Test plan
- **Reset and idle:** assert rst 2 cycles, then idle. Required: count = 0, empty = 1, full = 0, rvalid = 0, rdata = 0, overflow = underflow = 0.
- **Fill and overflow:** DEPTH = 16, write 0x00..0x0F on consecutive cycles. Required: full = 1 after the 16th edge, almost_full = 1 from count = 14. A 17th write (0xAA) sets overflow, count stays 16, and no data is lost.
- **Drain and order:** from full, read 17 times. Required: rdata sequence 0x00..0x0F with rvalid each cycle, empty = 1 after the 16th read. The 17th read sets underflow with rvalid = 0, and rdata holds 0x0F.
- **Simultaneous ops:**
  - At count = 0 with we&&re: write accepted, read rejected, count = 1, underflow sets.
  - At count = 16 with we&&re: both accepted, count stays 16, overflow stays 0.
  - At count = 5 with we&&re: count stays 5.
- **Wrap-around:** push and pop 40 random words while holding count between 1 and 3. Required: pointers wrap at least twice, all data matches a reference queue, and count always equals the model.
- **Reset mid-operation:** with count = 7, assert rst together with we&&re. Required: next-cycle count = 0, empty = 1, rvalid = 0, and a subsequent write of 0x5C followed by a read returns 0x5C.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The master side is the producer/consumer logic; the slave side is the FIFO itself.
interface sync_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              we;
   logic [DATA_W-1:0] wdata;
   logic              re;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              underflow;

   modport master (
      output we, wdata, re,
      input  rdata, rvalid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  we, wdata, re,
      output rdata, rvalid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_param #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst,
   sync_fifo_param_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic full, empty;
   logic wr_ok, rd_ok;

   // Status is decoded only from the count register, so no we/re path reaches the flags.
   always_comb begin
      full  = (count_q == DEPTH_C);
      empty = (count_q == '0);
   end

   // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
   always_comb begin
      rd_ok = bus.re && !empty;
      wr_ok = bus.we && (!full || rd_ok);
   end

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_ok) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (rd_ok) begin
         rptr_d   = rptr_q + AW'(1);
         rdata_d  = mem_q[rptr_q];
         rvalid_d = 1'b1;
      end

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (bus.we && !wr_ok) begin
         overflow_d = 1'b1;
      end
      if (bus.re && !rd_ok) begin
         underflow_d = 1'b1;
      end
   end

   // Storage carries no reset so it maps onto block RAM; stale words are never readable.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem_q[wptr_q] <= bus.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.rdata        = rdata_q;
   assign bus.rvalid       = rvalid_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed-vector bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=14, AE=2).
// Expected values come from a queue-based reference of the FIFO behaviour.
module tb_sync_fifo_param;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int AF     = 14;
   localparam int AE     = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   sync_fifo_param #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       rst;
      logic       we;
      logic [7:0] wdata;
      logic       re;
      int         exp_count;
      logic       exp_rvalid;
      logic [7:0] exp_rdata;
      logic       exp_ovf;
      logic       exp_unf;
   } vec_t;

   vec_t tbl[$];

   logic [7:0] mq[$];
   logic [7:0] m_rdata;
   logic       m_rvalid;
   logic       m_ovf;
   logic       m_unf;

   int checks = 0;
   int errors = 0;
   int vec_no = 0;

   // Reference behaviour: pop before push so a full FIFO accepts a write alongside a read.
   function automatic void predict(inout vec_t v);
      bit rd_ok, wr_ok;
      if (v.rst) begin
         mq.delete();
         m_rdata  = 8'h00;
         m_rvalid = 1'b0;
         m_ovf    = 1'b0;
         m_unf    = 1'b0;
      end else begin
         rd_ok = v.re && (mq.size() > 0);
         wr_ok = v.we && ((mq.size() < DEPTH) || rd_ok);
         m_rvalid = 1'b0;
         if (rd_ok) begin
            m_rdata  = mq.pop_front();
            m_rvalid = 1'b1;
         end
         if (wr_ok) mq.push_back(v.wdata);
         if (v.we && !wr_ok) m_ovf = 1'b1;
         if (v.re && !rd_ok) m_unf = 1'b1;
      end
      v.exp_count  = mq.size();
      v.exp_rvalid = m_rvalid;
      v.exp_rdata  = m_rdata;
      v.exp_ovf    = m_ovf;
      v.exp_unf    = m_unf;
   endfunction

   function automatic vec_t mk(logic r, logic w, logic [7:0] d, logic rd);
      vec_t v;
      v.rst = r; v.we = w; v.wdata = d; v.re = rd;
      v.exp_count = 0; v.exp_rvalid = 0; v.exp_rdata = 0; v.exp_ovf = 0; v.exp_unf = 0;
      predict(v);
      return v;
   endfunction

   task automatic add(logic r, logic w, logic [7:0] d, logic rd);
      tbl.push_back(mk(r, w, d, rd));
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", vec_no, name, act, exp);
      end
   endtask

   task automatic run(vec_t v);
      @(negedge clk);
      rst       = v.rst;
      bus.we    = v.we;
      bus.wdata = v.wdata;
      bus.re    = v.re;
      @(posedge clk);
      #1;
      $display("vec %0d: rst=%0b we=%0b wdata=%02h re=%0b -> count=%0d rvalid=%0b rdata=%02h ovf=%0b unf=%0b",
               vec_no, v.rst, v.we, v.wdata, v.re, bus.count, bus.rvalid, bus.rdata,
               bus.overflow, bus.underflow);
      chk("count",        int'(bus.count),        v.exp_count);
      chk("full",         int'(bus.full),         int'(v.exp_count == DEPTH));
      chk("empty",        int'(bus.empty),        int'(v.exp_count == 0));
      chk("almost_full",  int'(bus.almost_full),  int'(v.exp_count >= AF));
      chk("almost_empty", int'(bus.almost_empty), int'(v.exp_count <= AE));
      chk("rvalid",       int'(bus.rvalid),       int'(v.exp_rvalid));
      chk("rdata",        int'(bus.rdata),        int'(v.exp_rdata));
      chk("overflow",     int'(bus.overflow),     int'(v.exp_ovf));
      chk("underflow",    int'(bus.underflow),    int'(v.exp_unf));
      vec_no++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pushes;
      int n;
      int op;
      vec_t v;

      bus.we    = 1'b0;
      bus.wdata = 8'h00;
      bus.re    = 1'b0;

      // Reset and idle.
      add(1, 0, 8'h00, 0);
      add(1, 0, 8'h00, 0);
      add(0, 0, 8'h00, 0);
      // Fill 0x00..0x0F, then a rejected 17th write.
      for (int i = 0; i < DEPTH; i++) add(0, 1, 8'(i), 0);
      add(0, 1, 8'hAA, 0);
      // Drain in order, then a rejected 17th read.
      for (int i = 0; i < DEPTH + 1; i++) add(0, 0, 8'h00, 1);
      // Simultaneous operations at count 0, 16 and 5.
      add(1, 0, 8'h00, 0);
      add(0, 1, 8'h33, 1);
      for (int i = 0; i < DEPTH - 1; i++) add(0, 1, 8'(8'h34 + i), 0);
      add(0, 1, 8'h77, 1);
      for (int i = 0; i < 11; i++) add(0, 0, 8'h00, 1);
      add(0, 1, 8'h88, 1);

      for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

      // Wrap-around: random traffic holding occupancy between 1 and 3.
      run(mk(1, 0, 8'h00, 0));
      run(mk(0, 1, 8'($urandom), 0));
      run(mk(0, 1, 8'($urandom), 0));
      pushes = 2;
      for (int c = 0; c < 300 && pushes < 40; c++) begin
         n  = mq.size();
         op = $urandom_range(0, 2);
         if (n <= 1 && op == 1) op = 0;
         if (n >= 3 && op == 0) op = 1;
         v = mk(0, op != 1, 8'($urandom), op != 0);
         if (v.we) pushes++;
         run(v);
      end
      chk("wrap_pushes_reached", int'(pushes >= 40), 1);

      // Reset mid-operation at count 7 with we and re active.
      run(mk(1, 0, 8'h00, 0));
      for (int i = 0; i < 7; i++) run(mk(0, 1, 8'(8'h60 + i), 0));
      run(mk(1, 1, 8'hEE, 1));
      run(mk(0, 1, 8'h5C, 0));
      run(mk(0, 0, 8'h00, 1));
      chk("reset_mid_readback", int'(bus.rdata), 8'h5C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
